seed_random_2_deal_controller: RTL and testbench



---
 rtl/seed_random_2_pkg.sv | 50 +++++
 rtl/seed_random_2_hand_accum.sv | 64 ++++++
 rtl/seed_random_2_deal_controller.sv | 183 ++++++++++++++++++
 tb/tb_seed_random_2_deal_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_random_2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seed_random_2_pkg
// Purpose  : Shared encodings and card-value helper for the blackjack deal
//            controller and its hand accumulators.
// Revision : 1.0 - initial release
// ============================================================================
package seed_random_2_pkg;

    // Controller states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEAL    = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_CAPT    = 3'd3;
    localparam logic [2:0] S_P_WAIT  = 3'd4;
    localparam logic [2:0] S_D_CHECK = 3'd5;
    localparam logic [2:0] S_RESULT  = 3'd6;

    // Round outcome as presented on result_o
    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_PUSH   = 2'b11
    } result_e;

    // Which hand the card currently being fetched belongs to
    typedef enum logic {
        TGT_PLAYER = 1'b0,
        TGT_DEALER = 1'b1
    } target_e;

    localparam logic [4:0] ACE_HIGH   = 5'd11;
    localparam logic [4:0] FACE_VALUE = 5'd10;

    // Point value of a valid rank (1..13); an ace is always first counted high
    function automatic logic [4:0] card_value(input logic [3:0] rank);
        logic [4:0] value;
        if (rank == 4'd1) begin
            value = ACE_HIGH;
        end else if (rank >= 4'd11) begin
            value = FACE_VALUE;
        end else begin
            value = {1'b0, rank};
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seed_random_2_hand_accum.sv
`default_nettype none
// ============================================================================
// Module   : seed_random_2_hand_accum
// Purpose  : One blackjack hand: running total plus count of aces still
//            valued at 11, with a single soft-ace correction per card.
// Revision : 1.0 - initial release
// ============================================================================
module seed_random_2_hand_accum
    import seed_random_2_pkg::*;
#(
    parameter int BLACKJACK = 21
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       accept_en_i,
    input  logic [3:0] rank_i,
    output logic [5:0] total_o,
    output logic [5:0] next_total_o
);

    localparam logic [5:0] BJ_TOTAL = 6'(BLACKJACK);

    logic [5:0] total_q, total_d;
    // Two soft aces always exceed 21 and get corrected, so at most one
    // remains soft after any card; two bits cover the transient sum.
    logic [1:0] soft_q, soft_d;

    logic       w_is_ace;
    logic [1:0] w_soft_sum;
    logic [5:0] w_sum;

    // Add the card value, then demote one soft ace if that busts the hand
    always_comb begin
        w_is_ace   = (rank_i == 4'd1);
        w_soft_sum = soft_q + {1'b0, w_is_ace};
        w_sum      = total_q + {1'b0, card_value(rank_i)};
        total_d    = w_sum;
        soft_d     = w_soft_sum;
        if ((w_sum > BJ_TOTAL) && (w_soft_sum != 2'd0)) begin
            total_d = w_sum - {1'b0, FACE_VALUE};
            soft_d  = w_soft_sum - 2'd1;
        end
    end

    // Hand registers: cleared at round start, updated on each accepted card
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= 6'd0;
            soft_q  <= 2'd0;
        end else if (clear_i) begin
            total_q <= 6'd0;
            soft_q  <= 2'd0;
        end else if (accept_en_i) begin
            total_q <= total_d;
            soft_q  <= soft_d;
        end
    end

    assign total_o      = total_q;
    assign next_total_o = total_d;

endmodule
`default_nettype wire

// File: rtl/seed_random_2_deal_controller.sv
`default_nettype none
// ============================================================================
// Module   : seed_random_2_deal_controller
// Purpose  : Blackjack round sequencer. Requests cards from the random card
//            counter, filters invalid ranks, keeps both hands and decides
//            the outcome.
// Revision : 1.0 - initial release
// ============================================================================
module seed_random_2_deal_controller
    import seed_random_2_pkg::*;
#(
    parameter int CARD_W       = 8,
    parameter int DEALER_STAND = 17,
    parameter int BLACKJACK    = 21
) (
    input  logic              clk_dc_i,
    input  logic              rst_dc_i,
    input  logic              start_i,
    input  logic              hit_i,
    input  logic              stand_i,
    input  logic [CARD_W-1:0] card_i,
    output logic              req_card_o,
    output logic [5:0]        player_total_o,
    output logic [5:0]        dealer_total_o,
    output logic [3:0]        last_rank_o,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [1:0]        result_o
);

    localparam logic [5:0] BJ_TOTAL    = 6'(BLACKJACK);
    localparam logic [5:0] STAND_TOTAL = 6'(DEALER_STAND);

    logic [2:0] state_q, state_d;
    target_e    target_q, target_d;
    logic [2:0] deal_idx_q, deal_idx_d;   // 0..3 while dealing, 4 afterwards
    result_e    result_q, result_d;
    logic [3:0] last_rank_q;

    logic       w_rank_ok;
    logic       w_accept;
    logic       w_clear;
    logic [3:0] w_rank;
    logic [5:0] w_player_total, w_dealer_total;
    logic [5:0] w_player_next, w_dealer_next;
    logic       unused_card_bits;

    assign w_rank           = card_i[3:0];
    assign unused_card_bits = ^card_i[CARD_W-1:4];
    assign w_rank_ok        = (w_rank != 4'd0) && (w_rank <= 4'd13);
    assign w_accept         = (state_q == S_CAPT) && w_rank_ok;
    assign w_clear          = ((state_q == S_IDLE) || (state_q == S_RESULT)) && start_i;

    seed_random_2_hand_accum #(.BLACKJACK(BLACKJACK)) u_player_hand (
        .clk_i        (clk_dc_i),
        .rst_ni       (rst_dc_i),
        .clear_i      (w_clear),
        .accept_en_i  (w_accept && (target_q == TGT_PLAYER)),
        .rank_i       (w_rank),
        .total_o      (w_player_total),
        .next_total_o (w_player_next)
    );

    seed_random_2_hand_accum #(.BLACKJACK(BLACKJACK)) u_dealer_hand (
        .clk_i        (clk_dc_i),
        .rst_ni       (rst_dc_i),
        .clear_i      (w_clear),
        .accept_en_i  (w_accept && (target_q == TGT_DEALER)),
        .rank_i       (w_rank),
        .total_o      (w_dealer_total),
        .next_total_o (w_dealer_next)
    );

    // Round sequencing: next state, card target, deal position and outcome
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        deal_idx_d = deal_idx_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE, S_RESULT: begin
                if (start_i) begin
                    state_d    = S_DEAL;
                    deal_idx_d = 3'd0;
                    result_d   = RES_NONE;
                end
            end
            S_DEAL: begin
                state_d  = S_REQ;
                target_d = TGT_PLAYER;
            end
            S_REQ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                if (!w_rank_ok) begin
                    // Invalid rank: ask again for the same hand
                    state_d = S_REQ;
                end else if (deal_idx_q < 3'd3) begin
                    // Deal cards are fetched back to back, alternating P/D
                    deal_idx_d = deal_idx_q + 3'd1;
                    target_d   = deal_idx_q[0] ? TGT_PLAYER : TGT_DEALER;
                    state_d    = S_REQ;
                end else if (deal_idx_q == 3'd3) begin
                    // Last deal card is the dealer's, so the player total is final
                    deal_idx_d = 3'd4;
                    state_d    = (w_player_total == BJ_TOTAL) ? S_D_CHECK : S_P_WAIT;
                end else if (target_q == TGT_PLAYER) begin
                    if (w_player_next > BJ_TOTAL) begin
                        state_d  = S_RESULT;
                        result_d = RES_DEALER;
                    end else if (w_player_next == BJ_TOTAL) begin
                        state_d = S_D_CHECK;
                    end else begin
                        state_d = S_P_WAIT;
                    end
                end else begin
                    state_d = S_D_CHECK;
                end
            end
            S_P_WAIT: begin
                if (stand_i) begin
                    state_d = S_D_CHECK;
                end else if (hit_i) begin
                    state_d  = S_REQ;
                    target_d = TGT_PLAYER;
                end
            end
            S_D_CHECK: begin
                if (w_dealer_total < STAND_TOTAL) begin
                    state_d  = S_REQ;
                    target_d = TGT_DEALER;
                end else begin
                    state_d = S_RESULT;
                    if ((w_dealer_total > BJ_TOTAL) || (w_player_total > w_dealer_total)) begin
                        result_d = RES_PLAYER;
                    end else if (w_dealer_total > w_player_total) begin
                        result_d = RES_DEALER;
                    end else begin
                        result_d = RES_PUSH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk_dc_i or negedge rst_dc_i) begin
        if (!rst_dc_i) begin
            state_q    <= S_IDLE;
            target_q   <= TGT_PLAYER;
            deal_idx_q <= 3'd0;
            result_q   <= RES_NONE;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            deal_idx_q <= deal_idx_d;
            result_q   <= result_d;
        end
    end

    // Rank of the most recently accepted card
    always_ff @(posedge clk_dc_i or negedge rst_dc_i) begin
        if (!rst_dc_i) begin
            last_rank_q <= 4'd0;
        end else if (w_accept) begin
            last_rank_q <= w_rank;
        end
    end

    assign req_card_o     = (state_q == S_REQ);
    assign player_total_o = w_player_total;
    assign dealer_total_o = w_dealer_total;
    assign last_rank_o    = last_rank_q;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_RESULT);
    assign result_valid_o = (state_q == S_RESULT);
    assign result_o       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_seed_random_2_deal_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_random_2_deal_controller
// Purpose  : Directed self-checking bench for the blackjack deal controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_random_2_deal_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, hit_i, stand_i;
    logic [7:0] card_i;
    logic       req_card_o;
    logic [5:0] player_total_o, dealer_total_o;
    logic [3:0] last_rank_o;
    logic       busy_o, result_valid_o;
    logic [1:0] result_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulse_cyc[8];
    logic [7:0] card_q[$];

    seed_random_2_deal_controller #(
        .CARD_W(8), .DEALER_STAND(17), .BLACKJACK(21)
    ) dut (
        .clk_dc_i       (clk),
        .rst_dc_i       (rst_n),
        .start_i        (start_i),
        .hit_i          (hit_i),
        .stand_i        (stand_i),
        .card_i         (card_i),
        .req_card_o     (req_card_o),
        .player_total_o (player_total_o),
        .dealer_total_o (dealer_total_o),
        .last_rank_o    (last_rank_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle pulse on start_i, returns on the following falling edge
    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Answer n card requests from card_q, recording when each was seen
    task automatic serve(input int n);
        int seen = 0;
        int budget = 0;
        while ((seen < n) && (budget < 60)) begin
            if (req_card_o === 1'b1) begin
                card_i = (card_q.size() > 0) ? card_q.pop_front() : 8'd0;
                pulse_cyc[seen] = cyc;
                seen++;
                if (seen == n) break;
            end
            @(negedge clk);
            budget++;
        end
        checks++;
        if (seen != n) begin
            errors++;
            $display("FAIL serve_pulses: saw %0d req pulses, required %0d", seen, n);
        end
    endtask

    // Count request pulses over a number of falling edges
    task automatic count_reqs(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (req_card_o === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        int n;
        // Power-on reset
        repeat (3) @(negedge clk);
        checks++;
        if ({req_card_o, player_total_o, dealer_total_o, last_rank_o, busy_o, result_valid_o, result_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b p=%0d d=%0d rank=%0d busy=%b rv=%b res=%b, required all 0",
                     req_card_o, player_total_o, dealer_total_o, last_rank_o, busy_o, result_valid_o, result_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Abort a round partway through the deal
        pulse_start();
        card_q = '{8'd10, 8'd9};
        serve(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd10 || dealer_total_o !== 6'd9) begin
            errors++;
            $display("FAIL partial_deal: p=%0d d=%0d, required p=10 d=9", player_total_o, dealer_total_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_card_o, player_total_o, dealer_total_o, last_rank_o, busy_o, result_valid_o, result_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_midround: got req=%b p=%0d d=%0d rank=%0d busy=%b rv=%b res=%b, required all 0",
                     req_card_o, player_total_o, dealer_total_o, last_rank_o, busy_o, result_valid_o, result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        count_reqs(10, n);
        checks++;
        if (n != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: req pulses=%0d busy=%b, required 0 and 0", n, busy_o);
        end
    endtask

    task automatic test_deal();
        int n;
        pulse_start();
        card_q = '{8'd10, 8'd9, 8'd7, 8'd5};
        serve(4);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL deal_gap%0d: gap=%0d cycles, required 2", i, pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd17 || dealer_total_o !== 6'd14 || busy_o !== 1'b1 ||
            result_valid_o !== 1'b0 || last_rank_o !== 4'd5) begin
            errors++;
            $display("FAIL deal_totals: p=%0d d=%0d busy=%b rv=%b rank=%0d, required 17 14 1 0 5",
                     player_total_o, dealer_total_o, busy_o, result_valid_o, last_rank_o);
        end
        count_reqs(6, n);
        checks++;
        if (n != 0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL deal_pwait: req pulses=%0d busy=%b, required 0 and 1", n, busy_o);
        end
    endtask

    task automatic test_hit_bust();
        int n;
        hit_i = 1'b1;
        @(negedge clk);
        hit_i = 1'b0;
        card_q = '{8'd8};
        serve(1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd25 || dealer_total_o !== 6'd14 || result_o !== 2'b10 ||
            result_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_bust: p=%0d d=%0d res=%b rv=%b busy=%b, required 25 14 10 1 0",
                     player_total_o, dealer_total_o, result_o, result_valid_o, busy_o);
        end
        count_reqs(5, n);
        checks++;
        if (n != 0 || result_o !== 2'b10 || dealer_total_o !== 6'd14) begin
            errors++;
            $display("FAIL bust_hold: req pulses=%0d res=%b d=%0d, required 0 10 14", n, result_o, dealer_total_o);
        end
    endtask

    task automatic test_soft_ace();
        pulse_start();
        checks++;
        if (result_o !== 2'b00 || result_valid_o !== 1'b0 || player_total_o !== 6'd0) begin
            errors++;
            $display("FAIL restart_clear: res=%b rv=%b p=%0d, required 00 0 0", result_o, result_valid_o, player_total_o);
        end
        card_q = '{8'd1, 8'd6, 8'd5, 8'd10};
        serve(4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd16 || dealer_total_o !== 6'd16) begin
            errors++;
            $display("FAIL soft_deal: p=%0d d=%0d, required 16 16", player_total_o, dealer_total_o);
        end
        hit_i = 1'b1;
        @(negedge clk);
        hit_i = 1'b0;
        card_q = '{8'd9};
        serve(1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd15 || busy_o !== 1'b1 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL soft_adjust: p=%0d busy=%b rv=%b, required 15 1 0", player_total_o, busy_o, result_valid_o);
        end
        stand_i = 1'b1;
        @(negedge clk);
        stand_i = 1'b0;
        card_q = '{8'd4};
        serve(1);
        repeat (3) @(negedge clk);
        checks++;
        if (dealer_total_o !== 6'd20 || result_o !== 2'b10 || result_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL dealer_draw: d=%0d res=%b rv=%b, required 20 10 1", dealer_total_o, result_o, result_valid_o);
        end
    endtask

    task automatic test_reject();
        int n;
        pulse_start();
        card_q = '{8'hA0, 8'h5E, 8'h13};
        serve(3);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL retry_gap%0d: gap=%0d cycles, required 2", i, pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd0 || dealer_total_o !== 6'd0) begin
            errors++;
            $display("FAIL reject_hold: p=%0d d=%0d, required 0 0", player_total_o, dealer_total_o);
        end
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd3 || last_rank_o !== 4'd3) begin
            errors++;
            $display("FAIL reject_accept: p=%0d rank=%0d, required 3 3", player_total_o, last_rank_o);
        end
        card_q = '{8'd9, 8'd7, 8'd8};
        serve(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (player_total_o !== 6'd10 || dealer_total_o !== 6'd17 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reject_deal: p=%0d d=%0d busy=%b, required 10 17 1", player_total_o, dealer_total_o, busy_o);
        end
        // Hit and stand together: stand takes priority
        hit_i   = 1'b1;
        stand_i = 1'b1;
        @(negedge clk);
        hit_i   = 1'b0;
        stand_i = 1'b0;
        count_reqs(4, n);
        checks++;
        if (n != 0 || result_valid_o !== 1'b1 || result_o !== 2'b10 || player_total_o !== 6'd10) begin
            errors++;
            $display("FAIL hit_stand_tie: req pulses=%0d rv=%b res=%b p=%0d, required 0 1 10 10",
                     n, result_valid_o, result_o, player_total_o);
        end
    endtask

    task automatic test_natural_push();
        int n;
        pulse_start();
        card_q = '{8'd1, 8'd10, 8'd13, 8'd1};
        serve(4);
        repeat (3) @(negedge clk);
        checks++;
        if (player_total_o !== 6'd21 || dealer_total_o !== 6'd21 || result_o !== 2'b11 ||
            result_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL natural_push: p=%0d d=%0d res=%b rv=%b busy=%b, required 21 21 11 1 0",
                     player_total_o, dealer_total_o, result_o, result_valid_o, busy_o);
        end
        count_reqs(4, n);
        checks++;
        if (n != 0 || result_o !== 2'b11) begin
            errors++;
            $display("FAIL natural_hold: req pulses=%0d res=%b, required 0 11", n, result_o);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        hit_i   = 1'b0;
        stand_i = 1'b0;
        card_i  = 8'd0;
        test_reset();
        test_deal();
        test_hit_bust();
        test_soft_ace();
        test_reject();
        test_natural_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
